// File: rtl/mem_ctl_pipe_if.sv
// Request/response bus between the decoder's request FIFO, the memory
// back end and the response FIFO. The master side is whoever feeds requests
// and absorbs responses; the slave side is the memory controller.
interface mem_ctl_pipe_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 22
);
    logic [1:0]            mem_req_rd_cmd;
    logic [ADDR_WIDTH-1:0] mem_req_rd_addr;
    logic [DATA_WIDTH-1:0] mem_req_rd_dta;
    logic                  mem_req_rd_en;
    logic                  mem_req_rd_valid;
    logic [DATA_WIDTH-1:0] mem_res_wr_dta;
    logic                  mem_res_wr_en;
    logic                  mem_res_wr_almost_full;

    modport master (
        output mem_req_rd_cmd,
        output mem_req_rd_addr,
        output mem_req_rd_dta,
        output mem_req_rd_valid,
        output mem_res_wr_almost_full,
        input  mem_req_rd_en,
        input  mem_res_wr_dta,
        input  mem_res_wr_en
    );

    modport slave (
        input  mem_req_rd_cmd,
        input  mem_req_rd_addr,
        input  mem_req_rd_dta,
        input  mem_req_rd_valid,
        input  mem_res_wr_almost_full,
        output mem_req_rd_en,
        output mem_res_wr_dta,
        output mem_res_wr_en
    );
endinterface

// File: rtl/mem_ctl_pipe.sv
// Parametrised memory back end. Executes NOOP/REFRESH/READ/WRITE requests
// against an internal word array, returns read data through a fixed-latency
// pipeline, models refresh stalls on the request strobe, and keeps a
// saturating count of accesses to illegal addresses (out of range or the
// trap address).
module mem_ctl_pipe #(
    parameter int                   DATA_WIDTH     = 64,
    parameter int                   ADDR_WIDTH     = 22,
    parameter int                   DEPTH          = 4194304,
    parameter int                   READ_LATENCY   = 1,
    parameter int                   REFRESH_CYCLES = 4,
    parameter logic [ADDR_WIDTH-1:0] ADDR_ERR      = '1
) (
    input  logic                clk,
    input  logic                rst,
    mem_ctl_pipe_if.slave       bus,
    output logic                refresh_busy,
    output logic [15:0]         err_addr_cnt
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RCNT_W = (REFRESH_CYCLES > 0) ? $clog2(REFRESH_CYCLES + 1) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [RCNT_W-1:0]   RCNT_LOAD = RCNT_W'(REFRESH_CYCLES);

    typedef enum logic [1:0] {
        CMD_NOOP    = 2'd0,
        CMD_REFRESH = 2'd1,
        CMD_READ    = 2'd2,
        CMD_WRITE   = 2'd3
    } cmd_e;

    cmd_e                  cmd;
    logic                  is_read;
    logic                  is_write;
    logic                  is_refresh;
    logic                  addr_legal;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  pipe_v [READ_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_d [READ_LATENCY];

    logic [RCNT_W-1:0]     rcnt;
    logic [RCNT_W-1:0]     rcnt_next;
    logic                  rd_en_q;

    assign cmd        = cmd_e'(bus.mem_req_rd_cmd);
    assign is_read    = bus.mem_req_rd_valid && (cmd == CMD_READ);
    assign is_write   = bus.mem_req_rd_valid && (cmd == CMD_WRITE);
    assign is_refresh = bus.mem_req_rd_valid && (cmd == CMD_REFRESH);
    assign addr_legal = ({1'b0, bus.mem_req_rd_addr} < DEPTH_EXT) &&
                        (bus.mem_req_rd_addr != ADDR_ERR);
    assign idx        = bus.mem_req_rd_addr[IDX_W-1:0];
    assign rd_word    = addr_legal ? mem[idx] : '0;

    assign bus.mem_req_rd_en  = rd_en_q;
    assign bus.mem_res_wr_en  = pipe_v[READ_LATENCY-1];
    assign bus.mem_res_wr_dta = pipe_d[READ_LATENCY-1];

    // Store legal writes; contents survive reset, illegal writes are dropped.
    always_ff @(posedge clk) begin
        if (rst && is_write && addr_legal) begin
            mem[idx] <= bus.mem_req_rd_dta;
        end
    end

    // Read pipeline: stage 0 captures the pre-write array word, the last stage drives the response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= is_read;
            pipe_d[0] <= is_read ? rd_word : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    // Next refresh count: reload on REFRESH (even mid-stall), otherwise count down to zero.
    always_comb begin
        rcnt_next = rcnt;
        if (is_refresh) begin
            rcnt_next = RCNT_LOAD;
        end else if (rcnt != '0) begin
            rcnt_next = rcnt - 1'b1;
        end
    end

    // Refresh stall state and the registered request strobe it gates together with backpressure.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rcnt         <= '0;
            refresh_busy <= 1'b0;
            rd_en_q      <= 1'b0;
        end else begin
            rcnt         <= rcnt_next;
            refresh_busy <= (rcnt_next != '0);
            rd_en_q      <= ~bus.mem_res_wr_almost_full & (rcnt_next == '0);
        end
    end

    // Saturating count of READ/WRITE accesses that hit an illegal address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_addr_cnt <= '0;
        end else if ((is_read || is_write) && !addr_legal && (err_addr_cnt != 16'hffff)) begin
            err_addr_cnt <= err_addr_cnt + 16'd1;
        end
    end

endmodule
